// File: rtl/tsc_multimode.sv
// tsc_multimode: transient capture into a circular pre-trigger buffer
// with framed, oldest-first serial readout of the captured window.
module tsc_multimode #(
    parameter int DW    = 8,
    parameter int DEPTH = 32,
    parameter int POST  = 16,
    parameter int TW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          sbf,
    input  logic          rdy,
    input  logic [DW-1:0] dat,
    input  logic [DW-1:0] trig_lvl,
    input  logic [1:0]    trig_mode,
    output logic          req,
    output logic          trd,
    output logic          cd,
    output logic          sd,
    output logic [TW-1:0] trig_tm,
    output logic          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DW + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_REC, S_POST, S_DONE, S_SEND
    } state_t;

    state_t state, nxt;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rd, pcnt;
    logic [AW:0]   count, scnt;
    logic [TW-1:0] timer;
    logic [DW-1:0] prev, cur, sh;
    logic [BW-1:0] bcnt;
    logic          prev_v, start_q, sbf_q;
    logic          start_e, sbf_e, acc, hit;
    logic          last_post, bit_end, last_bit;

    assign start_e   = start & ~start_q;
    assign sbf_e     = sbf & ~sbf_q;
    assign req       = (state == S_REC) || (state == S_POST);
    assign busy      = req || (state == S_SEND);
    assign acc       = rdy & req;
    assign last_post = pcnt == AW'(POST - 1);
    assign bit_end   = bcnt == BW'(DW + 1);
    assign last_bit  = bit_end && (scnt == (AW+1)'(1));
    assign cur       = mem[rd];
    assign sh        = cur << (bcnt - BW'(1));

    // trigger condition for the sample currently on dat
    always_comb begin
        hit = 1'b0;
        unique case (trig_mode)
            2'b00:   hit = dat > trig_lvl;
            2'b01:   hit = prev_v && (prev <= trig_lvl) && (dat > trig_lvl);
            2'b10:   hit = dat < trig_lvl;
            default: hit = 1'b0;
        endcase
    end

    // serial line: start bit, data MSB first, stop bit; idle high
    always_comb begin
        sd = 1'b1;
        if (state == S_SEND && bcnt == '0) begin
            sd = 1'b0;
        end else if (state == S_SEND && !bit_end) begin
            sd = sh[DW-1];
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    // next-state logic; start beats sbf when both edge in DONE
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (start_e) nxt = S_REC;
            S_REC:  if (acc && hit) nxt = S_POST;
            S_POST: if (acc && last_post) nxt = S_DONE;
            S_DONE: begin
                if (start_e)    nxt = S_REC;
                else if (sbf_e) nxt = S_SEND;
            end
            S_SEND: if (last_bit) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    // sample buffer; contents survive reset
    always_ff @(posedge clk) begin
        if (acc && !reset) mem[wp] <= dat;
    end

    // pointers, counters, flags and the serial sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b1;
            sbf_q   <= 1'b1;
            wp      <= '0;
            rd      <= '0;
            pcnt    <= '0;
            count   <= '0;
            scnt    <= '0;
            timer   <= '0;
            prev    <= '0;
            prev_v  <= 1'b0;
            bcnt    <= '0;
            trd     <= 1'b0;
            cd      <= 1'b0;
            trig_tm <= '0;
        end else begin
            start_q <= start;
            sbf_q   <= sbf;
            if ((state == S_IDLE || state == S_DONE) && start_e) begin
                wp     <= '0;
                count  <= '0;
                timer  <= '0;
                trd    <= 1'b0;
                cd     <= 1'b0;
                prev_v <= 1'b0;
            end
            if (acc) begin
                wp     <= wp + AW'(1);
                timer  <= timer + TW'(1);
                prev   <= dat;
                prev_v <= 1'b1;
                if (count != (AW+1)'(DEPTH)) count <= count + (AW+1)'(1);
            end
            if (state == S_REC && acc && hit) begin
                trig_tm <= timer;
                pcnt    <= '0;
            end
            if (state == S_POST && acc) begin
                pcnt <= pcnt + AW'(1);
                if (last_post) trd <= 1'b1;
            end
            if (state == S_DONE && !start_e && sbf_e) begin
                rd   <= wp - count[AW-1:0];
                scnt <= count;
                bcnt <= '0;
            end
            if (state == S_SEND) begin
                if (bit_end) begin
                    bcnt <= '0;
                    rd   <= rd + AW'(1);
                    scnt <= scnt - (AW+1)'(1);
                    if (last_bit) cd <= 1'b1;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tsc_multimode.sv
// tb_tsc_multimode: trigger table, directed corner sequences and
// randomized captures checked against a sample-list model.
module tb_tsc_multimode;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int POST  = 16;
    localparam int TW    = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          sbf = 1'b0;
    logic          rdy = 1'b0;
    logic [DW-1:0] dat = '0;
    logic [DW-1:0] trig_lvl = '0;
    logic [1:0]    trig_mode = '0;
    logic          req, trd, cd, sd, busy;
    logic [TW-1:0] trig_tm;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] stim [256];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] lvl;
        logic [7:0] d0;
        logic [7:0] d1;
        int         tm;
    } vec_t;

    vec_t tbl [11];

    tsc_multimode #(.DW(DW), .DEPTH(DEPTH), .POST(POST), .TW(TW)) dut (
        .clk(clk), .reset(reset), .start(start), .sbf(sbf),
        .rdy(rdy), .dat(dat), .trig_lvl(trig_lvl),
        .trig_mode(trig_mode), .req(req), .trd(trd), .cd(cd),
        .sd(sd), .trig_tm(trig_tm), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        sbf   = 1'b0;
        rdy   = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic arm();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] d);
        rdy = 1'b1;
        dat = d;
        tick();
        rdy = 1'b0;
    endtask

    // index of the first sample meeting the trigger rule, -1 if none
    function automatic int model_trig(input logic [1:0] m,
                                      input logic [DW-1:0] l,
                                      input int len);
        for (int k = 0; k < len; k++) begin
            if (m == 2'd0 && stim[k] > l) return k;
            if (m == 2'd1 && k > 0 && stim[k-1] <= l && stim[k] > l)
                return k;
            if (m == 2'd2 && stim[k] < l) return k;
        end
        return -1;
    endfunction

    task automatic send_check(input int te);
        int n, first;
        logic [DW+1:0] fr;
        n = te + POST + 1;
        if (n > DEPTH) n = DEPTH;
        first = te + POST + 1 - n;
        sbf = 1'b0;
        tick();
        sbf = 1'b1;
        for (int j = 0; j < n; j++) begin
            fr = '0;
            for (int b = 0; b < DW + 2; b++) begin
                tick();
                fr = {fr[DW:0], sd};
            end
            chk("frame", fr, {1'b0, stim[first+j], 1'b1});
        end
        chk("cd_early", cd, 1'b0);
        chk("trd_hold", trd, 1'b1);
        tick();
        chk("cd_end", cd, 1'b1);
        chk("sd_end", sd, 1'b1);
        chk("busy_end", busy, 1'b0);
    endtask

    task automatic run(input logic [1:0] m, input logic [DW-1:0] l,
                       input int len, input int gap, input bit pre,
                       input bit mid, input bit snd, output int te);
        int nacc;
        te = model_trig(m, l, len);
        do_reset();
        trig_mode = m;
        trig_lvl  = l;
        if (pre) begin
            repeat (3) begin
                feed(8'hAA);
                tick();
            end
        end
        arm();
        nacc = (te < 0) ? len : te + POST + 1;
        for (int k = 0; k < nacc; k++) begin
            if (te >= 0 && k == nacc - 1) chk("trd_early", trd, 1'b0);
            if (mid && k == 1) start = 1'b1;
            feed(stim[k]);
            start = 1'b0;
            repeat (gap) tick();
        end
        if (te < 0) begin
            chk("notrig_trd", trd, 1'b0);
            chk("notrig_busy", busy, 1'b1);
        end else begin
            feed(8'h00);
            feed(8'h00);
            chk("trd", trd, 1'b1);
            chk("req_off", req, 1'b0);
            chk("busy_off", busy, 1'b0);
            chk("trig_tm", trig_tm, TW'(te));
            if (snd) send_check(te);
        end
    endtask

    initial begin
        int te;

        tbl[0]  = '{2'd0, 8'h50, 8'h40, 8'h60, 1};
        tbl[1]  = '{2'd0, 8'h50, 8'h60, 8'h10, 0};
        tbl[2]  = '{2'd0, 8'h50, 8'h50, 8'h50, -1};
        tbl[3]  = '{2'd1, 8'h80, 8'h90, 8'h90, -1};
        tbl[4]  = '{2'd1, 8'h80, 8'h80, 8'h81, 1};
        tbl[5]  = '{2'd1, 8'h80, 8'hFF, 8'h00, -1};
        tbl[6]  = '{2'd2, 8'h20, 8'h20, 8'h1F, 1};
        tbl[7]  = '{2'd2, 8'h20, 8'h00, 8'hFF, 0};
        tbl[8]  = '{2'd3, 8'h00, 8'hFF, 8'hFF, -1};
        tbl[9]  = '{2'd0, 8'hFF, 8'hFF, 8'hFF, -1};
        tbl[10] = '{2'd2, 8'h00, 8'h00, 8'h00, -1};

        // reset with start held high
        reset = 1'b1;
        start = 1'b1;
        repeat (3) tick();
        chk("rst_req", req, 1'b0);
        chk("rst_trd", trd, 1'b0);
        chk("rst_cd", cd, 1'b0);
        chk("rst_sd", sd, 1'b1);
        chk("rst_tm", trig_tm, '0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        repeat (3) tick();
        chk("held_busy", busy, 1'b0);
        chk("held_req", req, 1'b0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk("rearm_busy", busy, 1'b1);
        chk("rearm_req", req, 1'b1);

        // trigger rule table
        for (int i = 0; i < 11; i++) begin
            do_reset();
            trig_mode = tbl[i].mode;
            trig_lvl  = tbl[i].lvl;
            arm();
            feed(tbl[i].d0);
            feed(tbl[i].d1);
            repeat (POST) feed(tbl[i].lvl);
            chk("tbl_trd", trd, tbl[i].tm >= 0);
            chk("tbl_busy", busy, tbl[i].tm < 0);
            if (tbl[i].tm >= 0) chk("tbl_tm", trig_tm, TW'(tbl[i].tm));
        end

        // ramp, mode 00, level 0xD5
        for (int k = 0; k < 256; k++) stim[k] = DW'(k);
        run(2'd0, 8'hD5, 256, 0, 1'b0, 1'b0, 1'b1, te);
        chk("ramp_tm", trig_tm, 214);
        chk("ramp_first", stim[te + POST + 1 - DEPTH], 8'hC7);

        // rising crossing, first sample cannot trigger
        stim[0] = 8'h90;
        stim[1] = 8'h90;
        stim[2] = 8'h10;
        stim[3] = 8'h81;
        for (int k = 4; k < 20; k++) stim[k] = 8'h00;
        run(2'd1, 8'h80, 20, 0, 1'b0, 1'b0, 1'b1, te);
        chk("rise_tm", trig_tm, 3);

        // trigger on the very first sample: 17-sample window
        stim[0] = 8'hFF;
        for (int k = 1; k < 17; k++) stim[k] = 8'h00;
        run(2'd0, 8'h80, 17, 0, 1'b0, 1'b0, 1'b1, te);
        chk("first_tm", trig_tm, 0);

        // sparse rdy, rdy in IDLE, start edge during capture
        for (int k = 0; k < 100; k++) stim[k] = DW'(k * 3);
        run(2'd0, 8'h60, 100, 2, 1'b1, 1'b1, 1'b1, te);
        chk("sparse_tm", trig_tm, 33);

        // reset mid-send, then a lone sbf edge
        for (int k = 0; k < 40; k++) stim[k] = DW'($urandom);
        stim[5] = 8'hFF;
        run(2'd0, 8'hFE, 40, 0, 1'b0, 1'b0, 1'b0, te);
        sbf = 1'b0;
        tick();
        sbf = 1'b1;
        repeat (15) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_sd", sd, 1'b1);
        chk("mid_cd", cd, 1'b0);
        chk("mid_trd", trd, 1'b0);
        chk("mid_busy", busy, 1'b0);
        sbf = 1'b0;
        tick();
        sbf = 1'b1;
        tick();
        chk("sbf_ign_sd", sd, 1'b1);
        chk("sbf_ign_busy", busy, 1'b0);
        tick();
        chk("sbf_ign_sd2", sd, 1'b1);

        // start and sbf edges together in DONE
        run(2'd0, 8'hFE, 40, 0, 1'b0, 1'b0, 1'b0, te);
        tick();
        start = 1'b1;
        sbf   = 1'b1;
        tick();
        chk("both_busy", busy, 1'b1);
        chk("both_req", req, 1'b1);
        chk("both_sd", sd, 1'b1);
        chk("both_trd", trd, 1'b0);
        tick();
        chk("both_sd2", sd, 1'b1);
        start = 1'b0;
        sbf   = 1'b0;

        // randomized captures
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 100; k++) stim[k] = DW'($urandom);
            run(2'($urandom_range(0, 3)), DW'($urandom),
                100, int'($urandom_range(0, 2)),
                1'($urandom), 1'($urandom), 1'b1, te);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tsc_multimode.md
# tsc_multimode

Parametrised successor to the transient signal capture block. It sits between the ADC array (req/rdy/dat handshake) and the external controller. It records samples continuously into a circular buffer until a programmable trigger fires, then captures a fixed number of post-trigger samples and flags completion. On request it shifts the whole window out oldest-first as framed serial data.

## Interface
- DW, 8: sample width in bits.
- DEPTH, 32: buffer depth in samples; power of 2, ≥4.
- POST, 16: post-trigger samples captured after the trigger sample; 1..DEPTH-1.
- TW, 32: timer / trigger-time width.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; rising edge (synchronously detected) arms capture.
- sbf  in  1  level; rising edge requests buffer send.
- rdy  in  1  ADC sample valid, one cycle per sample.
- dat  in  DW  ADC sample, unsigned.
- trig_lvl  in  DW  trigger threshold, unsigned.
- trig_mode  in  2  00 above (dat>lvl); 01 rising crossing (prev≤lvl && dat>lvl); 10 below (dat<lvl); 11 never.
- req  out  1  sample request to ADC.
- trd  out  1  capture complete (triggered + POST samples held).
- cd  out  1  send complete.
- sd  out  1  serial data; idles high.
- trig_tm  out  TW  timer value of the triggering sample.
- busy  out  1  high in RECORD, POST, SEND.

## Operation
- Reset values: req=0, trd=0, cd=0, sd=1, trig_tm=0, busy=0. State is IDLE; wp, count and timer are 0. Edge-detect history regs reset to 1, so inputs held high through reset do not fire. Buffer RAM is not cleared.
- States: IDLE, RECORD, POST, DONE, SEND.
- Accepted sample: rdy=1 while req=1. rdy with req=0 is ignored.
- Each accepted sample performs: mem[wp]←dat; wp←wp+1 mod DEPTH; count←min(count+1, DEPTH); timer←timer+1 mod 2^TW. The timer value before the increment is the sample index.
- IDLE/DONE + start edge: clear wp, count, timer, trd, cd and the prev-sample valid flag. Go to RECORD.
- start edges in RECORD/POST/SEND are ignored.
- RECORD: evaluate trig_mode on each accepted sample; the sample is stored regardless.
  - Mode 01 needs a previous accepted sample, so the first sample after start never triggers in mode 01.
  - On trigger: trig_tm←sample index; go to POST with post counter = 0.
  - Mode 11 records indefinitely until reset.
- POST: count accepted samples. When the POST-th is stored, set trd=1 and go to DONE.
- DONE + sbf edge: go to SEND with rd = wp−count mod DEPTH.
- DONE + simultaneous start and sbf edges: start wins.
- sbf edges outside DONE are ignored.
- SEND: each sample is framed as a start bit 0, DW data bits MSB first, then a stop bit 1 (DW+2 cycles per sample). Samples go out oldest-first, count samples in total; rd wraps mod DEPTH.
  - After the last stop bit: cd=1, sd=1, go to IDLE.
  - cd holds until the next start edge or reset. trd holds through SEND.
- Reset in any state takes effect at the next edge. Outputs return to reset values, and any in-flight frame is abandoned.

## Timing
- An edge on start/sbf is detected when the input is sampled 1 with history 0.
- start edge sampled at edge N → state RECORD and req=1 from N+1.
- req=1 in RECORD and POST only. req drops on the edge that sets trd.
- Trigger sample accepted at edge k → POST from k+1. The same edge registers trig_tm.
- trd rises on the edge that accepts the POST-th post-trigger sample.
- sbf edge sampled at edge M → sd=0 (first start bit) from M+1.
- Each bit lasts exactly 1 clk. Total send time is count×(DW+2) cycles. cd rises on the edge ending the final stop bit.
- Window at trd is 1 trigger + POST post samples + up to DEPTH−1−POST pre-trigger samples (fewer if not yet recorded).

## Test plan
- Reset held 3 cycles with start=1: req=0, trd=0, cd=0, sd=1, trig_tm=0, busy=0. No capture after release until start falls and rises again.
- Mode 00, lvl=0xD5, rdy every cycle, dat ramp 0x00,0x01,…: trigger on 0xD6, trig_tm=214; trd after 16 more samples, req=0, count=32.
  - Then sbf: 320 cycles of frames carrying 0xC7..0xE6 in order, then cd=1, sd=1.
- Mode 01, lvl=0x80, dat 0x90,0x90,0x10,0x81: no trigger on samples 0–1; trigger on index 3, trig_tm=3.
- Mode 00, first sample 0xFF, then 16 samples of 0x00: trig_tm=0, count=17; send takes 170 cycles and starts with the 0xFF frame 0,1,1,1,1,1,1,1,1,1.
- rdy pulsed every 3rd cycle and also while in IDLE: only pulses with req=1 store. start edge during RECORD is ignored, and trig_tm is unchanged.
- Reset mid-SEND, then sbf edge: sd=1, cd=0 next cycle and the sbf is ignored. Start and sbf edges on the same cycle in DONE: RECORD entered, no serial frame.
